// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU, single-cycle logic/arith/LUI ops and
// an iterative 1-bit-per-cycle shifter behind a start/busy/done handshake.
//
// Ports:
//   clk          in  rising-edge clock
//   reset        in  synchronous active-high reset
//   start        in  op request, sampled only in IDLE or DONE
//   ALUOperation in  4-bit op code, sampled with start
//   A, B         in  operands (B is also the shift source), sampled with start
//   shamt        in  shift amount, sampled with start
//   busy         out high while the shifter is iterating
//   done         out one-cycle pulse, ALUResult/Zero valid for the new op
//   ALUResult    out registered result, held until the next op completes
//   Zero         out registered (ALUResult == 0)
module alu_seq_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;

    state_e                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_WIDTH-1:0]  res_q;
    logic                   zero_q;
    logic [DATA_WIDTH-1:0]  work_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic                   dir_left_q;

    logic [DATA_WIDTH-1:0]  alu_d;
    logic [DATA_WIDTH-1:0]  work_d;
    logic                   is_shift;
    logic                   accept;

    // Single-cycle result. Shift codes yield B here, which is the
    // correct result only for shamt == 0; nonzero shifts go iterative.
    always_comb begin
        alu_d = '0;
        unique case (ALUOperation)
            OP_AND:  alu_d = A & B;
            OP_OR:   alu_d = A | B;
            OP_NOR:  alu_d = ~(A | B);
            OP_ADD:  alu_d = A + B;
            OP_SUB:  alu_d = A - B;
            OP_LUI:  alu_d = {B[15:0], {(DATA_WIDTH-16){1'b0}}};
            OP_SRL:  alu_d = B;
            OP_SLL:  alu_d = B;
            default: alu_d = '0;
        endcase
    end

    always_comb begin
        is_shift = (ALUOperation == OP_SRL) || (ALUOperation == OP_SLL);
        accept   = start && (state_q != S_SHIFT);
        work_d   = dir_left_q ? (work_q << 1) : (work_q >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b1;
            work_q     <= '0;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept && is_shift && (shamt != '0)) begin
                        state_q    <= S_SHIFT;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        work_q     <= B;
                        cnt_q      <= shamt;
                        dir_left_q <= (ALUOperation == OP_SLL);
                    end else if (accept) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= alu_d;
                        zero_q  <= (alu_d == '0);
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - 1'b1;
                    // Last step: commit the shifted value in the same edge.
                    if (cnt_q == SHAMT_WIDTH'(1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= work_d;
                        zero_q  <= (work_d == '0);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ALUResult = res_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed scoreboard bench for alu_seq_exec.
// Expected results are queued at start and popped on each done pulse.
module tb_alu_seq_exec;

    localparam int DW = 32;
    localparam int SW = 5;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          zero;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [SW-1:0] sh;
    logic          busy;
    logic          done;
    logic [DW-1:0] res;
    logic          zero;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    alu_seq_exec #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ALUOperation(op),
        .A           (a),
        .B           (b),
        .shamt       (sh),
        .busy        (busy),
        .done        (done),
        .ALUResult   (res),
        .Zero        (zero)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [DW-1:0] x,
                                   input logic [DW-1:0] y, input logic [SW-1:0] s);
        exp_t e;
        case (o)
            4'd0:    e.res = x & y;
            4'd1:    e.res = x | y;
            4'd2:    e.res = ~(x | y);
            4'd3:    e.res = x + y;
            4'd4:    e.res = x - y;
            4'd5:    e.res = y << 16;
            4'd6:    e.res = y >> s;
            4'd7:    e.res = y << s;
            default: e.res = '0;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock; sample 1 time unit after the edge and score any done pulse.
    task automatic tick(output bit saw);
        exp_t e;
        @(posedge clk);
        #1;
        saw = done;
        if (done) begin
            chk("done_busy_excl", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", res, e.res);
                chk("zero", {31'd0, zero}, {31'd0, e.zero});
            end
        end
    endtask

    // Issue one op, optionally poke an ignored start mid-flight, then
    // check latency and busy-cycle count against the expected latency.
    task automatic run(input string tag, input logic [3:0] o, input logic [DW-1:0] x,
                       input logic [DW-1:0] y, input logic [SW-1:0] s,
                       input int lat, input int poke_at);
        bit saw;
        int cyc;
        int nbusy;
        op = o; a = x; b = y; sh = s; start = 1'b1;
        sb.push_back(model(o, x, y, s));
        cyc = 0;
        nbusy = 0;
        saw = 0;
        while (!saw && cyc < 100) begin
            tick(saw);
            cyc++;
            if (busy) nbusy++;
            start = 1'b0;
            // Scramble inputs: the op in flight must use captured operands.
            op = 4'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            sh = SW'($urandom);
            if (cyc == poke_at) start = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_busy_cycles"}, nbusy, lat - 1);
    endtask

    initial begin
        bit saw;
        int ndone;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; sh = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", res, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        reset = 1'b0;

        run("add_ovf", 4'b0011, 32'h7FFFFFFF, 32'd1, 5'd0, 1, 0);
        chk("add_val", res, 32'h80000000);
        run("sub_zero", 4'b0100, 32'h1234, 32'h1234, 5'd0, 1, 0);
        chk("sub_zflag", {31'd0, zero}, 32'd1);
        run("lui", 4'b0101, 32'h0, 32'hABCD, 5'd0, 1, 0);
        chk("lui_val", res, 32'hABCD0000);
        run("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 1, 0);
        run("or", 4'b0001, 32'h0000_00F0, 32'h0F00_0000, 5'd0, 1, 0);
        run("nor", 4'b0010, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 1, 0);
        run("sub_wrap", 4'b0100, 32'd0, 32'd1, 5'd0, 1, 0);
        run("sll0", 4'b0111, 32'd0, 32'hDEAD_BEEF, 5'd0, 1, 0);
        run("srl0", 4'b0110, 32'd0, 32'h1357_9BDF, 5'd0, 1, 0);

        run("sll31", 4'b0111, 32'd0, 32'd1, 5'd31, 32, 5);
        chk("sll31_val", res, 32'h80000000);

        // Reset mid-shift aborts with no done and clears the result.
        op = 4'b0110; b = 32'hF000_0000; sh = 5'd4; start = 1'b1;
        tick(saw);
        start = 1'b0;
        chk("shift_busy", {31'd0, busy}, 32'd1);
        chk("shift_hold", res, 32'h80000000);
        reset = 1'b1;
        tick(saw);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", res, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        ndone = 0;
        repeat (6) begin
            tick(saw);
            if (saw) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("idle_hold", res, 32'd0);

        run("srl4", 4'b0110, 32'd0, 32'hF000_0000, 5'd4, 5, 0);
        chk("srl4_val", res, 32'h0F000000);

        // Start held across DONE: back-to-back done pulses.
        op = 4'b0000; a = 32'h00FF_F0F0; b = 32'hFF0F_00FF; start = 1'b1;
        sb.push_back(model(op, a, b, sh));
        tick(saw);
        chk("b2b_first", {31'd0, saw}, 32'd1);
        op = 4'b1111;
        sb.push_back(model(op, a, b, sh));
        tick(saw);
        chk("b2b_second", {31'd0, saw}, 32'd1);
        chk("b2b_zero", {31'd0, zero}, 32'd1);
        start = 1'b0;
        tick(saw);
        chk("b2b_end", {31'd0, saw}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] ro;
            logic [SW-1:0] rs;
            ro = 4'($urandom_range(0, 9));
            rs = SW'($urandom_range(0, 7));
            run("rand", ro, $urandom, $urandom, rs,
                ((ro == 4'd6 || ro == 4'd7) && rs != 0) ? int'(rs) + 1 : 1, 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
